// File: rtl/dac_output_formatter.sv
// Final DAC output stage: registered input sample and select, optional saturating gain,
// ramp test pattern, offset-binary or two's-complement formatting into a glitch-free output register.
module dac_output_formatter #(
   parameter int WIDTH         = 16,
   parameter bit OFFSET_BINARY = 1'b1,
   parameter int GAIN_SHIFT    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inpsig,
   input  logic             select_i,
   output logic [WIDTH-1:0] DACout
);

   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] POS_FULL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] FMT_MASK = OFFSET_BINARY ? MSB_ONLY : '0;

   logic [WIDTH-1:0] r_in;
   logic             r_sel;
   logic [WIDTH-1:0] r_ramp;
   logic [WIDTH-1:0] w_gained;
   logic [WIDTH-1:0] w_value;
   logic [WIDTH-1:0] w_code;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in   <= '0;
         r_sel  <= 1'b0;
         r_ramp <= '0;
      end else begin
         r_in  <= inpsig;
         r_sel <= select_i;
         if (r_sel) begin
            r_ramp <= r_ramp + WIDTH'(1);
         end
      end
   end

   generate
      if (GAIN_SHIFT == 0) begin : g_no_gain
         assign w_gained = r_in;
      end else begin : g_gain
         logic [WIDTH+GAIN_SHIFT-1:0] w_shifted;
         logic [GAIN_SHIFT:0]         w_top;

         assign w_shifted = {{GAIN_SHIFT{r_in[WIDTH-1]}}, r_in} << GAIN_SHIFT;
         // The value fits in WIDTH bits only when every bit above the result sign bit matches it.
         assign w_top     = w_shifted[WIDTH+GAIN_SHIFT-1:WIDTH-1];

         always_comb begin
            w_gained = w_shifted[WIDTH-1:0];
            if (!((&w_top) || !(|w_top))) begin
               w_gained = w_shifted[WIDTH+GAIN_SHIFT-1] ? MSB_ONLY : POS_FULL;
            end
         end
      end
   endgenerate

   assign w_value = r_sel ? r_ramp : w_gained;
   assign w_code  = w_value ^ FMT_MASK;

   // Reset drives the zero-signal code so the DAC idles at mid-scale in offset-binary mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DACout <= FMT_MASK;
      end else begin
         DACout <= w_code;
      end
   end

endmodule

// File: tb/tb_dac_output_formatter.sv
// Directed self-checking bench for dac_output_formatter: formatting, saturation, ramp, wrap,
// pass-through and asynchronous reset, using four parameter variants driven from shared stimulus.
module tb_dac_output_formatter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] inpsig;
   logic        select_i;
   logic [15:0] out_ob;
   logic [15:0] out_g1;
   logic [15:0] out_tc;
   logic [7:0]  out_n8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dac_output_formatter #(.WIDTH(16), .OFFSET_BINARY(1'b1), .GAIN_SHIFT(0)) dut_ob (
      .clk(clk), .rst_n(rst_n), .inpsig(inpsig), .select_i(select_i), .DACout(out_ob));

   dac_output_formatter #(.WIDTH(16), .OFFSET_BINARY(1'b1), .GAIN_SHIFT(1)) dut_g1 (
      .clk(clk), .rst_n(rst_n), .inpsig(inpsig), .select_i(select_i), .DACout(out_g1));

   dac_output_formatter #(.WIDTH(16), .OFFSET_BINARY(1'b0), .GAIN_SHIFT(0)) dut_tc (
      .clk(clk), .rst_n(rst_n), .inpsig(inpsig), .select_i(select_i), .DACout(out_tc));

   dac_output_formatter #(.WIDTH(8), .OFFSET_BINARY(1'b1), .GAIN_SHIFT(0)) dut_n8 (
      .clk(clk), .rst_n(rst_n), .inpsig(inpsig[7:0]), .select_i(select_i), .DACout(out_n8));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] v, input logic s);
      @(negedge clk);
      inpsig   = v;
      select_i = s;
   endtask

   initial begin
      rst_n    = 1'b1;
      inpsig   = 16'h1234;
      select_i = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_ob", out_ob, 16'h8000);
      check("rst_async_g1", out_g1, 16'h8000);
      check("rst_async_tc", out_tc, 16'h0000);
      check("rst_async_n8", {8'h00, out_n8}, 16'h0080);
      tick(3);
      check("rst_hold_ob", out_ob, 16'h8000);
      check("rst_hold_tc", out_tc, 16'h0000);

      // Format and saturation vectors
      @(negedge clk);
      rst_n  = 1'b1;
      inpsig = 16'h0000;
      tick(2);
      check("fmt_zero_ob", out_ob, 16'h8000);
      check("fmt_zero_g1", out_g1, 16'h8000);
      check("fmt_zero_tc", out_tc, 16'h0000);

      drive(16'd1000, 1'b0);
      tick(1);
      check("latency_hold_ob", out_ob, 16'h8000);
      tick(1);
      check("fmt_1000_ob", out_ob, 16'h83E8);
      check("fmt_1000_tc", out_tc, 16'h03E8);
      check("fmt_1000_g1", out_g1, 16'h87D0);
      tick(8);

      drive(16'h8F8F, 1'b0);
      tick(2);
      check("fmt_8f8f_ob", out_ob, 16'h0F8F);
      check("pass_8f8f_tc", out_tc, 16'h8F8F);
      check("sat_neg_g1", out_g1, 16'h0000);

      drive(16'h4000, 1'b0);
      tick(2);
      check("sat_pos_g1", out_g1, 16'hFFFF);
      check("fmt_4000_ob", out_ob, 16'hC000);

      drive(16'h1000, 1'b0);
      tick(2);
      check("gain_1000_g1", out_g1, 16'hA000);
      check("fmt_1000h_ob", out_ob, 16'h9000);

      drive(16'hC001, 1'b0);
      tick(2);
      check("gain_neg_noclamp_g1", out_g1, 16'h0002);

      drive(16'h3FFF, 1'b0);
      tick(2);
      check("gain_edge_pos_g1", out_g1, 16'hFFFE);

      drive(16'h7FFF, 1'b0);
      tick(2);
      check("posfull_ob", out_ob, 16'hFFFF);
      check("posfull_tc", out_tc, 16'h7FFF);
      check("posfull_g1", out_g1, 16'hFFFF);

      drive(16'h8000, 1'b0);
      tick(2);
      check("negfull_ob", out_ob, 16'h0000);
      check("negfull_g1", out_g1, 16'h0000);

      // Ramp from reset, then hold and resume
      @(negedge clk);
      rst_n    = 1'b0;
      select_i = 1'b1;
      inpsig   = 16'h0000;
      #1;
      check("rst_midstream_ob", out_ob, 16'h8000);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      for (int k = 0; k < 5; k++) begin
         check("ramp_ob", out_ob, 16'h8000 + 16'(k));
         check("ramp_tc", out_tc, 16'(k));
         if (k == 2) check("ramp_nogain_g1", out_g1, 16'h8002);
         if (k < 4) tick(1);
      end

      drive(16'h0100, 1'b0);
      tick(1);
      check("ramp_tail_ob", out_ob, 16'h8005);
      tick(1);
      check("ramp_exit_ob", out_ob, 16'h8100);
      check("ramp_exit_g1", out_g1, 16'h8200);
      check("ramp_exit_tc", out_tc, 16'h0100);

      drive(16'h0100, 1'b1);
      tick(1);
      check("ramp_reentry_lat_ob", out_ob, 16'h8100);
      tick(1);
      check("ramp_held_ob", out_ob, 16'h8006);

      // Asynchronous reset between edges while streaming
      drive(16'h1000, 1'b0);
      tick(3);
      check("stream_ob", out_ob, 16'h9000);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_between_edges_ob", out_ob, 16'h8000);
      check("rst_between_edges_g1", out_g1, 16'h8000);
      check("rst_between_edges_tc", out_tc, 16'h0000);
      @(negedge clk);
      rst_n  = 1'b1;
      inpsig = 16'h2000;
      tick(1);
      check("post_rst_flushed_ob", out_ob, 16'h8000);
      tick(1);
      check("post_rst_first_ob", out_ob, 16'hA000);
      check("post_rst_first_g1", out_g1, 16'hC000);
      check("post_rst_first_tc", out_tc, 16'h2000);

      // Ramp wrap on the narrow instance
      @(negedge clk);
      rst_n    = 1'b0;
      select_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      check("wrap_start_n8", {8'h00, out_n8}, 16'h0080);
      tick(255);
      check("wrap_top_n8", {8'h00, out_n8}, 16'h007F);
      check("ramp_255_ob", out_ob, 16'h80FF);
      tick(1);
      check("wrap_zero_n8", {8'h00, out_n8}, 16'h0080);
      check("ramp_256_ob", out_ob, 16'h8100);
      tick(1);
      check("wrap_one_n8", {8'h00, out_n8}, 16'h0081);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
